// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory, decoder and redirect signals of the fetch queue
interface fetch_queue_if #(
  parameter int NBITS       = 8,
  parameter int NINSTR_BITS = 32
);
  logic                   mem_req;
  logic [NBITS-1:0]       mem_addr;
  logic                   mem_busy;
  logic                   mem_rvalid;
  logic [NINSTR_BITS-1:0] mem_rdata;
  logic                   instr_valid;
  logic [NINSTR_BITS-1:0] instr;
  logic [NBITS-1:0]       instr_pc;
  logic                   instr_ready;
  logic                   redirect;
  logic [NBITS-1:0]       redirect_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_busy, mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_busy, mem_rvalid, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with one outstanding request and a small FIFO
module fetch_queue #(
  parameter int          NBITS       = 8,
  parameter int          NINSTR_BITS = 32,
  parameter int          DEPTH       = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input logic             clock,
  input logic             reset,
  fetch_queue_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [NBITS-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [NINSTR_BITS-1:0] instr_mem_q [DEPTH];
  logic [NBITS-1:0]       pc_mem_q    [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Request and head-valid depend on redirect in the same cycle, so they stay combinational.
  assign bus.mem_req     = !reset && (state_q == FETCH) && (count_q < DEPTH_C) && !bus.redirect;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = !reset && (count_q != '0) && !bus.redirect;
  assign bus.instr       = instr_mem_q[rd_ptr_q];
  assign bus.instr_pc    = pc_mem_q[rd_ptr_q];

  assign accept = bus.mem_req && !bus.mem_busy;
  assign push   = (state_q == WAIT) && bus.mem_rvalid && !bus.redirect;
  assign pop    = bus.instr_valid && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // An outstanding request must still be retired, so WAIT becomes DRAIN unless its response is here now.
      case (state_q)
        FETCH:   state_d = FETCH;
        WAIT:    state_d = bus.mem_rvalid ? FETCH : DRAIN;
        DRAIN:   state_d = bus.mem_rvalid ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (accept) begin
            fetch_pc_d = fetch_pc_q + NBITS'(4);
            req_addr_d = fetch_pc_q;
            state_d    = WAIT;
          end
        end
        WAIT:    if (bus.mem_rvalid) state_d = FETCH;
        DRAIN:   if (bus.mem_rvalid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= NBITS'(RESET_PC);
      req_addr_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_addr_q;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   failed = 0;

  fetch_queue_if #(.NBITS(8), .NINSTR_BITS(32)) bus ();

  fetch_queue #(.NBITS(8), .NINSTR_BITS(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_busy = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    step();
    step();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    tests_run++;
    if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    release_reset();
    tests_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin
      failed++; $display("FAIL first_req: req %b addr %h want 1 00", bus.mem_req, bus.mem_addr);
    end
    tests_run++;
    if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL first_valid: got %b want 0", bus.instr_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    release_reset();
    bus.instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'(4 * k)) begin
        failed++; $display("FAIL stream_req%0d: req %b addr %h want 1 %h", k, bus.mem_req, bus.mem_addr, 8'(4 * k));
      end
      if (k > 0) begin
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(4 * (k - 1)) || bus.instr !== 32'hA000_0000 + 32'(k - 1)) begin
          failed++; $display("FAIL stream_head%0d: valid %b pc %h instr %h want 1 %h %h", k, bus.instr_valid,
                             bus.instr_pc, bus.instr, 8'(4 * (k - 1)), 32'hA000_0000 + 32'(k - 1));
        end
      end
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA000_0000 + 32'(k);
      #1;
      tests_run++;
      if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
        failed++; $display("FAIL stream_wait%0d: req %b valid %b want 0 0", k, bus.mem_req, bus.instr_valid);
      end
      step();
      bus.mem_rvalid = 1'b0;
      #1;
    end
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h0C || bus.instr !== 32'hA000_0003) begin
      failed++; $display("FAIL stream_last: valid %b pc %h instr %h want 1 0c a0000003", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_fill();
    do_reset();
    release_reset();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'(4 * k)) begin
        failed++; $display("FAIL fill_req%0d: req %b addr %h want 1 %h", k, bus.mem_req, bus.mem_addr, 8'(4 * k));
      end
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hB000_0000 + 32'(k);
      step();
      bus.mem_rvalid = 1'b0;
      #1;
    end
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00) begin
      failed++; $display("FAIL fill_full: req %b valid %b pc %h want 0 1 00", bus.mem_req, bus.instr_valid, bus.instr_pc);
    end
    step();
    step();
    tests_run++;
    if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL fill_hold: req %b want 0", bus.mem_req); end
    bus.instr_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL fill_ready_req: req %b want 0", bus.mem_req); end
    step();
    bus.instr_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h10 || bus.instr_pc !== 8'h04) begin
      failed++; $display("FAIL fill_refetch: req %b addr %h pc %h want 1 10 04", bus.mem_req, bus.mem_addr, bus.instr_pc);
    end
    step();
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'hB000_0004;
    bus.instr_ready = 1'b1;
    step();
    bus.mem_rvalid  = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    tests_run++;
    if (bus.instr_pc !== 8'h08 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h14) begin
      failed++; $display("FAIL fill_pushpop: pc %h req %b addr %h want 08 1 14", bus.instr_pc, bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_busy();
    do_reset();
    release_reset();
    bus.mem_busy = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin
        failed++; $display("FAIL busy_hold%0d: req %b addr %h want 1 00", k, bus.mem_req, bus.mem_addr);
      end
      step();
    end
    bus.mem_busy = 1'b0;
    step();
    tests_run++;
    if (bus.mem_req !== 1'b0) begin failed++; $display("FAIL busy_wait: req %b want 0", bus.mem_req); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hC000_0000;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_addr !== 8'h04 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00) begin
      failed++; $display("FAIL busy_advance: addr %h valid %b pc %h want 04 1 00", bus.mem_addr, bus.instr_valid, bus.instr_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    release_reset();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      failed++; $display("FAIL redir_cycle: req %b valid %b want 0 0", bus.mem_req, bus.instr_valid);
    end
    step();
    bus.redirect = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      failed++; $display("FAIL redir_drain: req %b valid %b want 0 0", bus.mem_req, bus.instr_valid);
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h40) begin
      failed++; $display("FAIL redir_refetch: valid %b req %b addr %h want 0 1 40", bus.instr_valid, bus.mem_req, bus.mem_addr);
    end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_1234;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h40 || bus.instr !== 32'h0000_1234) begin
      failed++; $display("FAIL redir_deliver: valid %b pc %h instr %h want 1 40 00001234", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    release_reset();
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    step();
    bus.mem_rvalid  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h80;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_cycle: req %b valid %b want 0 0", bus.mem_req, bus.instr_valid);
    end
    step();
    bus.redirect_pc = 8'h90;
    step();
    bus.redirect = 1'b0;
    #1;
    tests_run++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h90) begin
      failed++; $display("FAIL b2b_last: valid %b req %b addr %h want 0 1 90", bus.instr_valid, bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    release_reset();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h20;
    bus.mem_rvalid  = 1'b1;
    bus.mem_rdata   = 32'h2222_2222;
    step();
    bus.redirect   = 1'b0;
    bus.mem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h20) begin
      failed++; $display("FAIL coincide: valid %b req %b addr %h want 0 1 20", bus.instr_valid, bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    release_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFC;
    step();
    bus.redirect = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'hFC) begin
      failed++; $display("FAIL wrap_fc: req %b addr %h want 1 fc", bus.mem_req, bus.mem_addr);
    end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h3333_3333;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00 || bus.instr_pc !== 8'hFC) begin
      failed++; $display("FAIL wrap_00: req %b addr %h pc %h want 1 00 fc", bus.mem_req, bus.mem_addr, bus.instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    release_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h30;
    step();
    bus.redirect = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset        = 1'b0;
    bus.mem_busy = 1'b1;
    #1;
    tests_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin
      failed++; $display("FAIL rmid_first: req %b addr %h want 1 00", bus.mem_req, bus.mem_addr);
    end
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_0BAD;
    step();
    bus.mem_rvalid = 1'b0;
    #1;
    tests_run++;
    if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin
      failed++; $display("FAIL rmid_stray: valid %b req %b addr %h want 0 1 00", bus.instr_valid, bus.mem_req, bus.mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_busy();
    test_redirect_wait();
    test_back_to_back();
    test_coincide();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
